lynx_mem_arbiter: RTL and testbench

Slot-based arbiter that shares one single-port main-RAM bank between three requesters: CRTC video fetch, the Z80 CPU and the cassette loader. It sits between the CPU bus decode, the video address generator and the tape loader on one side, and the synchronous RAM macro on the other. Video gets deterministic bandwidth and the CPU gets bounded wait. The tape loader uses spare slots but cannot be starved.

---
 rtl/lynx_pkg.sv | 27 ++
 rtl/lynx_slot_sched.sv | 52 +++++
 rtl/lynx_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_lynx_mem_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lynx_pkg.sv
// Shared encodings for the Lynx main-RAM arbiter: slot numbers, access owners
// and the access FSM states.
package lynx_pkg;

    localparam logic [1:0] SLOT_VID0 = 2'd0;
    localparam logic [1:0] SLOT_CPU0 = 2'd1;
    localparam logic [1:0] SLOT_VID1 = 2'd2;
    localparam logic [1:0] SLOT_CPU1 = 2'd3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_TAPE = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    function automatic logic is_vid_slot(input logic [1:0] s);
        return (s == SLOT_VID0) || (s == SLOT_VID1);
    endfunction

endpackage

// File: rtl/lynx_slot_sched.sv
// Slot counter, tape starvation counter and per-slot winner selection.
// The winner is combinational; grant_o qualifies it with ce and an idle FSM.
module lynx_slot_sched
    import lynx_pkg::*;
#(
    parameter int TAPE_MAXWAIT = 8
) (
    input  logic   clock_i,
    input  logic   reset_i,
    input  logic   ce_i,
    input  logic   idle_i,
    input  logic   vid_req_i,
    input  logic   cpu_req_i,
    input  logic   tape_req_i,
    output owner_e winner_o,
    output logic   grant_o
);

    localparam logic [3:0] MAXW = 4'(TAPE_MAXWAIT);

    logic [1:0] slot_q, slot_d;
    logic [3:0] starve_q, starve_d;

    always_comb begin
        winner_o = OWN_NONE;
        // Even slots without a video request fall through to the odd-slot rule.
        if (is_vid_slot(slot_q) && vid_req_i)      winner_o = OWN_VID;
        else if ((starve_q == MAXW) && tape_req_i) winner_o = OWN_TAPE;
        else if (cpu_req_i)                        winner_o = OWN_CPU;
        else if (tape_req_i)                       winner_o = OWN_TAPE;

        grant_o = ce_i && idle_i && (winner_o != OWN_NONE);
        slot_d  = ce_i ? slot_q + 2'd1 : slot_q;

        starve_d = starve_q;
        if (!tape_req_i || (grant_o && (winner_o == OWN_TAPE)))
            starve_d = '0;
        else if (ce_i && !is_vid_slot(slot_q) && (starve_q != MAXW))
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            slot_q   <= SLOT_VID0;
            starve_q <= '0;
        end else begin
            slot_q   <= slot_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/lynx_mem_arbiter.sv
// Shares one synchronous single-port RAM between video, CPU and tape using
// a 4-slot schedule; each access is ISSUE then CAPTURE, ack two clocks after grant.
module lynx_mem_arbiter
    import lynx_pkg::*;
#(
    parameter int AW           = 14,
    parameter int DW           = 8,
    parameter int TAPE_MAXWAIT = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_a,
    output logic          vid_ack,
    output logic [DW-1:0] vid_q,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_d,
    output logic          cpu_wait,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_q,
    input  logic          tape_req,
    input  logic [AW-1:0] tape_a,
    input  logic [DW-1:0] tape_d,
    output logic          tape_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q
);

    state_e          state_q, state_d;
    owner_e          owner_q, winner;
    logic            grant;
    logic            mem_en_q, mem_we_q, acc_we_q;
    logic [AW-1:0]   mem_a_q, sel_a;
    logic [DW-1:0]   mem_d_q, sel_d, vid_q_q, cpu_q_q;
    logic            sel_we;
    logic            vid_ack_q, cpu_ack_q, tape_ack_q;

    lynx_slot_sched #(.TAPE_MAXWAIT(TAPE_MAXWAIT)) u_sched (
        .clock_i    (clock),
        .reset_i    (reset),
        .ce_i       (ce),
        .idle_i     (state_q == ST_IDLE),
        .vid_req_i  (vid_req),
        .cpu_req_i  (cpu_req),
        .tape_req_i (tape_req),
        .winner_o   (winner),
        .grant_o    (grant)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (grant) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        sel_a  = mem_a_q;
        sel_d  = mem_d_q;
        sel_we = 1'b0;
        unique case (winner)
            OWN_VID:  sel_a = vid_a;
            OWN_CPU:  begin sel_a = cpu_a;  sel_d = cpu_d;  sel_we = cpu_we; end
            OWN_TAPE: begin sel_a = tape_a; sel_d = tape_d; sel_we = 1'b1;   end
            default:  ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q    <= OWN_NONE;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            acc_we_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_d_q    <= '0;
            vid_q_q    <= '0;
            cpu_q_q    <= '0;
            vid_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            tape_ack_q <= 1'b0;
        end else begin
            mem_en_q   <= grant;
            mem_we_q   <= grant && sel_we;
            vid_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            tape_ack_q <= 1'b0;
            if (grant) begin
                owner_q  <= winner;
                acc_we_q <= sel_we;
                mem_a_q  <= sel_a;
                mem_d_q  <= sel_d;
            end
            // Read data is valid one clock after the RAM sampled the access.
            if (state_q == ST_CAPTURE) begin
                unique case (owner_q)
                    OWN_VID:  begin vid_q_q <= mem_q; vid_ack_q <= 1'b1; end
                    OWN_CPU:  begin
                        if (!acc_we_q) cpu_q_q <= mem_q;
                        cpu_ack_q <= 1'b1;
                    end
                    OWN_TAPE: tape_ack_q <= 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    assign mem_en   = mem_en_q;
    assign mem_we   = mem_we_q;
    assign mem_a    = mem_a_q;
    assign mem_d    = mem_d_q;
    assign vid_ack  = vid_ack_q;
    assign vid_q    = vid_q_q;
    assign cpu_ack  = cpu_ack_q;
    assign cpu_q    = cpu_q_q;
    assign tape_ack = tape_ack_q;
    assign cpu_wait = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_lynx_mem_arbiter.sv
// Directed bench for lynx_mem_arbiter with a behavioural synchronous RAM.
module tb_lynx_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b0;
    logic          vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, tape_req = 1'b0;
    logic [AW-1:0] vid_a = '0, cpu_a = '0, tape_a = '0;
    logic [DW-1:0] cpu_d = '0, tape_d = '0;
    logic          vid_ack, cpu_wait, cpu_ack, tape_ack;
    logic [DW-1:0] vid_q, cpu_q, mem_d, mem_q;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_a;

    always #5 clock = ~clock;

    lynx_mem_arbiter #(.AW(AW), .DW(DW), .TAPE_MAXWAIT(8)) u_dut (
        .clock(clock), .reset(reset), .ce(ce),
        .vid_req(vid_req), .vid_a(vid_a), .vid_ack(vid_ack), .vid_q(vid_q),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_wait(cpu_wait), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
        .tape_req(tape_req), .tape_a(tape_a), .tape_d(tape_d), .tape_ack(tape_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
    );

    // RAM model with a side port for preloading
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a = '0;
    logic [DW-1:0] pre_d = '0;
    always @(posedge clock) begin
        if (pre_we) ram[pre_a] <= pre_d;
        else if (mem_en) begin
            if (mem_we) ram[mem_a] <= mem_d;
            else        ram_q <= ram[mem_a];
        end
    end
    assign mem_q = ram_q;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int   en_tot = 0, vack_tot = 0, cack_tot = 0, tack_tot = 0, vack_cyc = 0;
    logic wait_at_ack = 1'b1;
    always @(negedge clock) begin
        if (mem_en) en_tot++;
        if (vid_ack) begin vack_tot++; vack_cyc = cyc; end
        if (cpu_ack) begin cack_tot++; wait_at_ack = cpu_wait; end
        if (tape_ack) tack_tot++;
    end

    int n_chk = 0, n_pass = 0;
    int en_b, vack_b, cack_b, tack_b, g_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic settle();
        @(negedge clock); #1;
    endtask

    task automatic snap();
        en_b = en_tot; vack_b = vack_tot; cack_b = cack_tot; tack_b = tack_tot;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        step();
        pre_we = 1'b0;
    endtask

    // One ce pulse followed by n-1 quiet clocks; ends just after a falling edge.
    task automatic run_slot(input int n, input bit drop_cpu);
        ce = 1'b1;
        step();
        g_cyc = cyc;
        ce = 1'b0;
        if (drop_cpu) cpu_req = 1'b0;
        repeat (n - 1) step();
        settle();
    endtask

    initial begin
        int t_early, c_early;
        preload(14'h0123, 8'h5A);
        preload(14'h0042, 8'h3C);
        chk("rst_mem_en",   mem_en,   0);
        chk("rst_mem_we",   mem_we,   0);
        chk("rst_mem_a",    mem_a,    0);
        chk("rst_mem_d",    mem_d,    0);
        chk("rst_vid_ack",  vid_ack,  0);
        chk("rst_cpu_ack",  cpu_ack,  0);
        chk("rst_tape_ack", tape_ack, 0);
        chk("rst_vid_q",    vid_q,    0);
        chk("rst_cpu_q",    cpu_q,    0);
        chk("rst_cpu_wait", cpu_wait, 0);
        reset = 1'b0;
        settle();

        // video only: grants on even slots, nothing on odd
        vid_req = 1'b1; vid_a = 14'h0123;
        snap(); run_slot(3, 0);
        chk("vid_s0_en",  en_tot - en_b, 1);
        chk("vid_s0_ack", vack_tot - vack_b, 1);
        chk("vid_s0_lat", vack_cyc - g_cyc, 2);
        chk("vid_s0_q",   vid_q, 8'h5A);
        snap(); run_slot(3, 0);
        chk("vid_s1_en",  en_tot - en_b, 0);
        snap(); run_slot(3, 0);
        chk("vid_s2_ack", vack_tot - vack_b, 1);
        snap(); run_slot(3, 0);
        chk("vid_s3_en",  en_tot - en_b, 0);
        vid_req = 1'b0;

        // CPU write then read at 0x2000 (slots 0 and 1)
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h2000; cpu_d = 8'hA5;
        #1 chk("cpu_wait_pend", cpu_wait, 1);
        snap(); run_slot(3, 0);
        chk("cpu_wr_ack",  cack_tot - cack_b, 1);
        chk("cpu_wr_ram",  ram[14'h2000], 8'hA5);
        chk("cpu_wr_q",    cpu_q, 8'h00);
        chk("cpu_wr_wait", wait_at_ack, 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_req = 1'b1;
        snap(); run_slot(3, 0);
        chk("cpu_rd_ack", cack_tot - cack_b, 1);
        chk("cpu_rd_q",   cpu_q, 8'hA5);
        cpu_req = 1'b0;

        // request dropped right after grant (slot 2), then nothing (slot 3)
        cpu_a = 14'h0042; cpu_req = 1'b1;
        snap(); run_slot(3, 1);
        chk("drop_ack", cack_tot - cack_b, 1);
        chk("drop_q",   cpu_q, 8'h3C);
        snap(); run_slot(3, 0);
        chk("drop_no_regrant", en_tot - en_b, 0);

        // ce every 2 clocks: every second ce ignored (slots 0..3)
        cpu_req = 1'b1;
        snap();
        repeat (4) run_slot(2, 0);
        chk("sp2_en",  en_tot - en_b, 2);
        chk("sp2_ack", cack_tot - cack_b, 2);
        cpu_req = 1'b0;
        vid_req = 1'b1;
        snap(); run_slot(3, 0);
        chk("sp2_slot0_vid", vack_tot - vack_b, 1);
        snap(); run_slot(3, 0);
        chk("sp2_slot1_idle", en_tot - en_b, 0);

        // tape starvation: video on even slots, CPU+tape contend on odd
        cpu_req = 1'b1; tape_req = 1'b1; tape_a = 14'h0100; tape_d = 8'h77;
        t_early = 0; c_early = 0;
        for (int k = 1; k <= 10; k++) begin
            run_slot(3, 0);
            snap(); run_slot(3, 0);
            if (k <= 8) begin
                t_early += tack_tot - tack_b;
                c_early += cack_tot - cack_b;
            end
            if (k == 9) begin
                chk("starve_tape_ack", tack_tot - tack_b, 1);
                chk("starve_cpu_ack",  cack_tot - cack_b, 0);
                chk("starve_cleared",  u_dut.u_sched.starve_q, 0);
            end
            if (k == 10) chk("starve_cpu_back", cack_tot - cack_b, 1);
        end
        chk("starve_tape_early", t_early, 0);
        chk("starve_cpu_early",  c_early, 8);
        chk("starve_tape_ram",   ram[14'h0100], 8'h77);
        cpu_req = 1'b0; tape_req = 1'b0;

        // reset during ISSUE (slot 2 grant)
        ce = 1'b1; step(); ce = 1'b0;
        chk("rst_issue_en_pre", mem_en, 1);
        #2 reset = 1'b1;
        #1 chk("rst_issue_en", mem_en, 0);
        snap();
        repeat (3) step();
        settle();
        chk("rst_issue_noack", vack_tot - vack_b, 0);
        chk("rst_issue_vid_q", vid_q, 8'h00);
        reset = 1'b0;
        snap(); run_slot(3, 0);
        chk("rst_first_slot0", vack_tot - vack_b, 1);
        chk("rst_first_q",     vid_q, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
